// File: rtl/instr_prefetch.sv
// instr_prefetch: sequential 16-bit instruction prefetch queue between imem and the IF/ID register.
// Optional feature macro PREFETCH_BYPASS_EN: an arriving fetch reaches the head outputs in the same cycle when the queue is empty.
module instr_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc,
  input  logic        out_ready,
  output logic        err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned RW = CW + 1;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } entry_t;

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_DROP,
    S_HALTED
  } state_t;

  state_t        state;
  state_t        state_nxt;
  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [15:0]   fetch_pc;
  logic [15:0]   req_pc;
  logic          halted;
  logic          err_q;

  logic redir;
  logic outstanding;
  logic rsp_take;
  logic rsp_keep;
  logic fifo_valid;
  logic full;
  logic room;
  logic pop;
  logic fifo_pop;
  logic push;
  logic push_ok;
  logic accept;
  logic byp;

  // Once halted, redirects are ignored entirely.
  assign redir       = redirect & ~halted;
  assign outstanding = (state == S_WAIT) | (state == S_DROP);
  assign rsp_take    = (state == S_WAIT) & imem_rvalid;
  assign rsp_keep    = rsp_take & ~redir;
  assign fifo_valid  = (count != '0);
  assign full        = (count == CW'(DEPTH));
  assign head        = mem[rd_ptr];

`ifdef PREFETCH_BYPASS_EN
  assign byp       = rsp_keep & (count == '0);
  assign out_valid = fifo_valid | byp;
  assign out_pc    = byp ? req_pc : head.pc;
  assign out_instr = byp ? imem_rdata : head.instr;
`else
  assign byp       = 1'b0;
  assign out_valid = fifo_valid;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
`endif

  assign pop      = out_valid & out_ready & ~redir;
  assign fifo_pop = pop & fifo_valid;
  // A bypassed word consumed this cycle never enters the FIFO.
  assign push     = rsp_keep & ~(byp & out_ready);
  assign push_ok  = push & ~full;

  // Entries held plus in flight, after this cycle's pop, must leave a free slot.
  assign room      = (RW'(count) + RW'(outstanding)) < (RW'(DEPTH) + RW'(pop));
  assign accept    = imem_req & imem_gnt;
  assign imem_addr = fetch_pc;
  assign err       = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (accept)      state_nxt = S_WAIT;
        else if (halted) state_nxt = S_HALTED;
      end
      S_WAIT: begin
        if (redir)            state_nxt = imem_rvalid ? S_FETCH : S_DROP;
        else if (imem_rvalid) state_nxt = accept ? S_WAIT : (halted ? S_HALTED : S_FETCH);
      end
      S_DROP: begin
        if (imem_rvalid) state_nxt = halted ? S_HALTED : S_FETCH;
      end
      default: state_nxt = S_HALTED;
    endcase
  end

  // A new fetch may chain onto the returning response in the same cycle.
  always_comb begin
    imem_req = 1'b0;
    if ((state == S_FETCH) || rsp_take)
      imem_req = rst & room & ~halted & ~redirect;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      halted   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      halted <= halted | halt;
      if ((imem_rvalid & ~outstanding) | (push & full))
        err_q <= 1'b1;
      if (redir) begin
        fetch_pc <= redirect_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (accept) begin
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + 16'd2;
        end
        if (push_ok)  wr_ptr <= wr_ptr + AW'(1);
        if (fifo_pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push_ok) - CW'(fifo_pop);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= {req_pc, imem_rdata};
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: fixed vector tables, directed corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_instr_prefetch;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        out_ready;
  logic        err;

  int nchk = 0;
  int nerr = 0;

  instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word_of(input logic [15:0] a);
    return (a * 16'd3) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: queue of delivered {pc, instr} plus in-flight bookkeeping.
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } ent_t;

  ent_t        q[$];
  bit          m_out, m_drop, m_halted, m_err;
  logic [15:0] m_fpc, m_rpc;

  // Memory responder state and stimulus knobs.
  bit          mem_pend;
  int          mem_cnt;
  logic [15:0] mem_addr;
  bit          s_gnt, s_rdy, s_redir, s_halt, s_spur;
  logic [15:0] s_rpc;
  int          s_lat;
  int          acc_dut;

  task automatic stim_idle();
    s_gnt = 0; s_rdy = 0; s_redir = 0; s_halt = 0; s_spur = 0; s_rpc = '0; s_lat = 1;
  endtask

  task automatic model_reset();
    q.delete();
    m_out = 0; m_drop = 0; m_halted = 0; m_err = 0; m_fpc = 16'h0000; m_rpc = '0;
  endtask

  // Called at posedge+1; holds reset for one cycle and checks reset values.
  task automatic do_reset(input bit keep_mem);
    rst = 1'b0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; out_ready = 0;
    redirect = 0; redirect_pc = '0; halt = 0;
    if (!keep_mem) mem_pend = 0;
    model_reset();
    #3;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // One clock cycle: drive, compare against the model, advance model and memory.
  task automatic step();
    bit   rv, mem_rv, redir, rsp, pop, ereq, acc;
    ent_t e;
    mem_rv = mem_pend && (mem_cnt == 0);
    rv     = mem_rv || s_spur;
    imem_gnt = s_gnt; out_ready = s_rdy; redirect = s_redir; redirect_pc = s_rpc; halt = s_halt;
    imem_rvalid = rv;
    imem_rdata  = mem_rv ? word_of(mem_addr) : 16'($urandom);
    #3;
    pop  = (q.size() > 0) && s_rdy;
    ereq = (!m_out || (rv && !m_drop)) &&
           ((q.size() + int'(m_out) - int'(pop)) < int'(DEPTH)) && !m_halted && !s_redir;
    chk("imem_req", imem_req, ereq);
    if (ereq) chk("imem_addr", imem_addr, m_fpc);
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_instr", out_instr, q[0].instr);
    end
    chk("err", err, m_err);
    if (imem_req && s_gnt) acc_dut++;

    redir = s_redir && !m_halted;
    rsp   = rv && m_out;
    if (rv && !m_out) m_err = 1;
    acc = ereq && s_gnt;
    if (redir) begin
      q.delete();
      m_fpc = s_rpc;
      if (rsp) begin m_out = 0; m_drop = 0; end
      else if (m_out) m_drop = 1;
    end else begin
      if (pop) void'(q.pop_front());
      if (rsp && !m_drop) begin
        e.pc = m_rpc; e.instr = word_of(m_rpc);
        q.push_back(e);
      end
      if (rsp) begin m_out = 0; m_drop = 0; end
      if (acc) begin m_out = 1; m_rpc = m_fpc; m_fpc = m_fpc + 16'd2; end
    end
    if (s_halt) m_halted = 1;

    if (mem_rv) mem_pend = 0;
    else if (mem_pend) mem_cnt--;
    if (imem_req && s_gnt) begin
      mem_pend = 1; mem_cnt = s_lat - 1; mem_addr = imem_addr;
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          rst_before;
    bit          gnt;
    bit          rv;
    bit          rdy;
    bit          e_req;
    logic [15:0] e_addr;
    bit          e_valid;
    logic [15:0] e_pc;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] rsp_addr;
  logic [15:0] got[$];
  int          acc_before;

  initial begin
    // Streaming with 1-cycle memory, then fill-to-full with out_ready low and drain.
    tbl.push_back('{1, 1, 0, 1, 1, 16'h0000, 0, 16'h0000});
    tbl.push_back('{0, 1, 1, 1, 1, 16'h0002, 0, 16'h0000});
    tbl.push_back('{0, 1, 1, 1, 1, 16'h0004, 1, 16'h0000});
    tbl.push_back('{0, 1, 1, 1, 1, 16'h0006, 1, 16'h0002});
    tbl.push_back('{0, 1, 1, 1, 1, 16'h0008, 1, 16'h0004});
    tbl.push_back('{0, 1, 1, 1, 1, 16'h000A, 1, 16'h0006});
    tbl.push_back('{1, 1, 0, 0, 1, 16'h0000, 0, 16'h0000});
    tbl.push_back('{0, 1, 1, 0, 1, 16'h0002, 0, 16'h0000});
    tbl.push_back('{0, 1, 1, 0, 1, 16'h0004, 1, 16'h0000});
    tbl.push_back('{0, 1, 1, 0, 1, 16'h0006, 1, 16'h0000});
    tbl.push_back('{0, 1, 1, 0, 0, 16'h0008, 1, 16'h0000});
    tbl.push_back('{0, 1, 0, 0, 0, 16'h0008, 1, 16'h0000});
    tbl.push_back('{0, 1, 0, 1, 1, 16'h0008, 1, 16'h0000});
    tbl.push_back('{0, 1, 1, 1, 1, 16'h000A, 1, 16'h0002});
    tbl.push_back('{0, 1, 1, 1, 1, 16'h000C, 1, 16'h0004});
    tbl.push_back('{0, 1, 1, 1, 1, 16'h000E, 1, 16'h0006});
    tbl.push_back('{0, 1, 1, 1, 1, 16'h0010, 1, 16'h0008});

    stim_idle();
    mem_pend = 0; mem_cnt = 0; mem_addr = '0; acc_dut = 0; rsp_addr = '0;
    rst = 1'b1;
    #1;
    do_reset(0);

    foreach (tbl[i]) begin
      if (tbl[i].rst_before && i != 0) do_reset(0);
      imem_gnt = tbl[i].gnt; imem_rvalid = tbl[i].rv; imem_rdata = word_of(rsp_addr);
      out_ready = tbl[i].rdy; redirect = 0; halt = 0;
      #3;
      chk($sformatf("tbl%0d_req", i), imem_req, tbl[i].e_req);
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].e_pc);
        chk($sformatf("tbl%0d_instr", i), out_instr, word_of(tbl[i].e_pc));
      end
      chk($sformatf("tbl%0d_err", i), err, 0);
      if (tbl[i].e_req && tbl[i].gnt) rsp_addr = tbl[i].e_addr;
      @(posedge clk); #1;
    end

    // Grant withheld: address holds, then the word is delivered once granted.
    stim_idle(); do_reset(0);
    s_rdy = 1;
    for (int k = 0; k < 3; k++) begin
      chk("gnt_hold_addr", imem_addr, 16'h0000);
      step();
    end
    chk("gnt_hold_addr_end", imem_addr, 16'h0000);
    s_gnt = 1;
    for (int k = 0; k < 6; k++) step();

    // Redirect while waiting on a 3-cycle memory.
    stim_idle(); do_reset(0);
    s_gnt = 1; s_rdy = 1; s_lat = 3;
    step();
    s_redir = 1; s_rpc = 16'h0100;
    step();
    s_redir = 0;
    chk("redir_flush_valid", out_valid, 0);
    got.delete();
    for (int k = 0; k < 24 && got.size() < 2; k++) begin
      if (out_valid) got.push_back(out_pc);
      step();
    end
    chk("redir_count", got.size(), 2);
    if (got.size() >= 2) begin
      chk("redir_pc0", got[0], 16'h0100);
      chk("redir_pc1", got[1], 16'h0102);
    end

    // Randomized traffic with redirects against the model.
    stim_idle(); do_reset(0);
    for (int k = 0; k < 3000; k++) begin
      s_gnt   = ($urandom % 4) != 0;
      s_rdy   = ((k / 64) % 2 == 1) ? (($urandom % 4) == 0) : (($urandom % 3) != 0);
      s_redir = ($urandom % 30) == 0;
      s_rpc   = 16'($urandom) & 16'hFFFE;
      s_lat   = 1 + int'($urandom % 3);
      step();
    end

    // Halt at cycle 5: in-flight word still lands, queue drains, redirect ignored.
    stim_idle(); do_reset(0);
    s_gnt = 1; s_rdy = 1;
    for (int k = 0; k < 5; k++) step();
    s_halt = 1;
    step();
    s_halt = 0;
    acc_before = acc_dut;
    for (int k = 0; k < 10; k++) begin
      s_redir = (k == 4);
      s_rpc   = 16'h0200;
      step();
    end
    s_redir = 0;
    chk("halt_no_accept", acc_dut - acc_before, 0);
    chk("halt_drained", out_valid, 0);

    // Response with nothing outstanding sets a sticky error.
    stim_idle(); do_reset(0);
    s_spur = 1;
    step();
    s_spur = 0;
    for (int k = 0; k < 3; k++) begin
      chk("err_sticky", err, 1);
      step();
    end

    // Reset mid-transaction: the late response flags an error.
    stim_idle(); do_reset(0);
    s_gnt = 1; s_lat = 3;
    step();
    s_gnt = 0;
    step();
    do_reset(1);
    for (int k = 0; k < 3; k++) step();
    chk("late_rvalid_err", err, 1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/instr_prefetch.md
# instr_prefetch

- Instruction prefetch queue between the instruction memory and the IF/ID pipeline register.
- Issues sequential 16-bit fetches ahead of the pipeline and buffers up to DEPTH {PC, instruction} pairs.
- Flushes and restarts on a branch/jump redirect from the EX/MEM stage.
- Absorbs variable instruction-memory latency so the IF/ID register sees a simple valid/ready stream.

## Interface
- DEPTH, 4, queue entries; power of two, 2..8.
- RESET_PC, 16'h0000, first fetch address after reset.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset; block in reset while 0.
- imem_req  out  1  fetch request.
- imem_addr  out  16  fetch address; valid while imem_req=1.
- imem_gnt  in  1  request accepted this cycle when imem_req & imem_gnt.
- imem_rvalid  in  1  response valid; arrives ≥1 cycle after acceptance.
- imem_rdata  in  16  instruction word; valid with imem_rvalid.
- redirect  in  1  pipeline redirect (taken branch/jump).
- redirect_pc  in  16  new fetch address; valid with redirect.
- halt  in  1  halt decoded; stop issuing fetches.
- out_valid  out  1  queue head valid.
- out_instr  out  16  head instruction.
- out_pc  out  16  head PC.
- out_ready  in  1  IF/ID write enable; pop when out_valid & out_ready.
- err  out  1  sticky protocol error.

## Operation
- Storage: DEPTH-entry circular FIFO of {pc[15:0], instr[15:0]} with read/write pointers and a count of 0..DEPTH.
- fetch_pc register: reset to RESET_PC; +2 (mod 2^16) on each accepted request.
- At most one request outstanding.
- imem_req=1 only when all hold:
  - state FETCH, or state WAIT with imem_rvalid this cycle;
  - count + outstanding − (pop this cycle) < DEPTH;
  - halted=0 and redirect=0.
- FSM states:
  - FETCH: no request outstanding. Accepted request → WAIT.
  - WAIT: one request outstanding. On imem_rvalid, push {req_pc, imem_rdata}. Then go to WAIT if a new request is accepted in the same cycle, else FETCH.
  - DROP: outstanding response is discarded. On imem_rvalid, discard the data and go to FETCH.
  - HALTED: no new requests. Any outstanding response still pushes. FIFO keeps draining.
- Redirect has priority over push and pop in the same cycle:
  - count←0 (FIFO flushed); fetch_pc←redirect_pc.
  - From WAIT, go to DROP unless imem_rvalid is also high that cycle; in that case discard the data and go to FETCH.
- halt is sampled each cycle; halted←1 is sticky until reset. redirect is ignored once halted=1.
- Pop and push in the same cycle are allowed; count is unchanged.
- err←1 (sticky) on:
  - imem_rvalid with no request outstanding;
  - push attempted with count=DEPTH.
- Reset (asynchronous):
  - state FETCH, fetch_pc=RESET_PC, count=0, halted=0, err=0;
  - FIFO storage cleared to 0;
  - imem_req=0 while rst=0;
  - out_valid=0, out_instr=16'h0000, out_pc=16'h0000.
- Reset asserted mid-transaction abandons the outstanding request; a late rvalid after reset flags err.

## Timing
- First imem_req: first cycle with rst=1, address RESET_PC.
- Latency without bypass: request accepted in cycle n, rvalid in n+1, pushed at the end of n+1, out_valid in n+2.
- Throughput: 1 instruction/cycle with single-cycle memory and out_ready=1. A new request can issue in the same cycle the previous response returns.
- out_valid, out_instr and out_pc are registered (FIFO head) and change only on clock edges.
- After redirect in cycle n:
  - out_valid=0 in n+1;
  - first request to redirect_pc in n+1 (from FETCH) or in the cycle after the dropped rvalid.

## Configuration
- PREFETCH_BYPASS_EN.
- Defined: when count=0 and imem_rvalid is accepted (not dropped), the head outputs are driven combinationally from {req_pc, imem_rdata} with out_valid=1 in the same cycle. If out_ready=1 that cycle, the entry is consumed and not pushed. Minimum latency becomes 1 cycle. Redirect in the same cycle suppresses the bypass.
- Undefined: outputs come purely from registered FIFO state; minimum latency is 2 cycles.

## Test plan
- Reset release, gnt=1, 1-cycle memory, out_ready=1:
  - out_pc = 0x0000, 0x0002, 0x0004, 0x0006 on consecutive cycles, first at cycle 2 after release;
  - err=0.
- out_ready=0, DEPTH=4: four entries buffered, imem_req drops to 0, imem_addr=0x0008. Raise out_ready: pops 0x0000..0x0006 in order and fetching resumes at 0x0008.
- gnt held 0 for 3 cycles with req=1: imem_addr stays constant and fetch_pc does not advance. The instruction is delivered once gnt rises.
- redirect with redirect_pc=0x0100 while in WAIT with a 3-cycle memory:
  - flush gives out_valid=0 next cycle;
  - the returning word is dropped;
  - next out_pc=0x0100, then 0x0102.
- halt=1 at cycle 5: no further accepted requests; the outstanding response is still delivered; the queue drains to out_valid=0; a later redirect has no effect.
- imem_rvalid=1 with nothing outstanding → err=1 next cycle and stays 1 until rst=0.
- With PREFETCH_BYPASS_EN: out_valid is coincident with the first imem_rvalid; out_pc=0x0000 at cycle 1.
